// File: rtl/prbs5_pkg.sv
// prbs5_pkg: shared types and constants for the PRBS5 (x^5 + x^3 + 1) checker.
//   state_t    : checker lock state {SEARCH, LOCKED}
//   PRBS_LEN   : shift register length (5)
//   TAP_A/B    : register taps feeding the predicted bit
//   FILL_W     : width of the fill counter (counts 0..PRBS_LEN)
//   prbs5_next : predicted next bit from the current register contents
package prbs5_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int PRBS_LEN = 5;
  localparam int TAP_A    = 4;
  localparam int TAP_B    = 2;
  localparam int FILL_W   = 3;

  // r[0] is the newest bit, so r[4] is the bit five positions back and r[2]
  // the bit three positions back: x[n] = x[n-5] ^ x[n-3].
  function automatic logic prbs5_next(input logic [PRBS_LEN-1:0] r);
    return r[TAP_A] ^ r[TAP_B];
  endfunction

endpackage

// File: rtl/prbs5_checker_if.sv
// prbs5_checker_if: bit-stream and status bundle of the PRBS5 checker.
//   din, din_vld : received serial bit and its qualifier
//   clr          : synchronous clear of the error (and bit) counters
//   locked       : checker is locked to the sequence
//   err_pulse    : one-cycle strobe per detected bit error
//   err_cnt      : saturating error count, ERR_W bits
//   bit_cnt      : saturating count of bits checked while locked
//                  (only when PRBS_CHK_BITCNT_EN is defined)
// Modports: master = stream source / status sink, slave = checker.
interface prbs5_checker_if #(
  parameter int ERR_W = 16
);
  logic             din;
  logic             din_vld;
  logic             clr;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
  logic [ERR_W+8-1:0] bit_cnt;

  modport master (output din, din_vld, clr,
                  input  locked, err_pulse, err_cnt, bit_cnt);
  modport slave  (input  din, din_vld, clr,
                  output locked, err_pulse, err_cnt, bit_cnt);
`else
  modport master (output din, din_vld, clr,
                  input  locked, err_pulse, err_cnt);
  modport slave  (input  din, din_vld, clr,
                  output locked, err_pulse, err_cnt);
`endif
endinterface

// File: rtl/prbs5_lfsr.sv
// prbs5_lfsr: reference shift register of the PRBS5 checker.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : shift one bit this cycle
//   ld_pred   : 1 = shift in the predicted bit (flywheel), 0 = shift in din
//   din       : received bit
//   clr_fill  : restart the fill count (resynchronisation)
//   r         : register contents, r[0] newest
//   fill      : number of bits loaded since the last restart, saturates at 5
//   pred      : predicted next bit
module prbs5_lfsr
  import prbs5_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                ld_pred,
  input  logic                din,
  input  logic                clr_fill,
  output logic [PRBS_LEN-1:0] r,
  output logic [FILL_W-1:0]   fill,
  output logic                pred
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PRBS_LEN);

  assign pred = prbs5_next(r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r    <= '0;
      fill <= '0;
    end else if (en) begin
      r <= {r[PRBS_LEN-2:0], (ld_pred ? pred : din)};
      if (clr_fill)
        fill <= '0;
      else if (fill != FILL_FULL)
        fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/prbs5_checker.sv
// prbs5_checker: self-synchronising serial PRBS5 checker.
// Searches for the x^5 + x^3 + 1 sequence in the received stream, locks after
// LOCK_CNT consecutive correct predictions, then free-runs its own reference
// and counts bit errors. UNLOCK_THR consecutive errors drop it back to search.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : prbs5_checker_if.slave (din, din_vld, clr in; locked,
//              err_pulse, err_cnt[, bit_cnt] out)
// Optional: define PRBS_CHK_BITCNT_EN to add bus.bit_cnt, the saturating
// count of valid bits checked while locked (BER = err_cnt / bit_cnt).
module prbs5_checker
  import prbs5_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_THR = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  prbs5_checker_if.slave   bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int XW = $clog2(UNLOCK_THR + 1);
  localparam logic [MW-1:0]     MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [XW-1:0]     MISS_LAST  = XW'(UNLOCK_THR - 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PRBS_LEN);

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef PRBS_CHK_BITCNT_EN
  function automatic logic [ERR_W+8-1:0] sat_inc_bits(input logic [ERR_W+8-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  state_t               state;
  logic [MW-1:0]        match_cnt;
  logic [XW-1:0]        miss_cnt;
  logic [PRBS_LEN-1:0]  r;
  logic [FILL_W-1:0]    fill;
  logic                 pred;
  logic                 bit_err;
  logic                 unlock_now;

  assign bit_err    = (bus.din != pred);
  assign unlock_now = bus.din_vld && (state == LOCKED) && bit_err &&
                      (miss_cnt == MISS_LAST);

  // Reference register: tracks din while searching, flywheels on its own
  // prediction once locked so one flipped bit costs exactly one error.
  prbs5_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.din_vld),
    .ld_pred  (state == LOCKED),
    .din      (bus.din),
    .clr_fill (unlock_now),
    .r        (r),
    .fill     (fill),
    .pred     (pred)
  );

  // Lock state machine, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SEARCH;
      match_cnt     <= '0;
      miss_cnt      <= '0;
      bus.locked    <= 1'b0;
      bus.err_pulse <= 1'b0;
      bus.err_cnt   <= '0;
`ifdef PRBS_CHK_BITCNT_EN
      bus.bit_cnt   <= '0;
`endif
    end else begin
      bus.err_pulse <= 1'b0;
      if (bus.din_vld) begin
        case (state)
          SEARCH: begin
            // An all-zero register predicts zeros forever; never count it.
            if (fill == FILL_FULL) begin
              if (!bit_err && (r != '0)) begin
                if (match_cnt == MATCH_LAST) begin
                  state      <= LOCKED;
                  bus.locked <= 1'b1;
                  match_cnt  <= '0;
                  miss_cnt   <= '0;
                end else begin
                  match_cnt <= match_cnt + 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end
          end
          LOCKED: begin
`ifdef PRBS_CHK_BITCNT_EN
            bus.bit_cnt <= sat_inc_bits(bus.bit_cnt);
`endif
            if (bit_err) begin
              bus.err_pulse <= 1'b1;
              bus.err_cnt   <= sat_inc_err(bus.err_cnt);
              if (miss_cnt == MISS_LAST) begin
                state      <= SEARCH;
                bus.locked <= 1'b0;
                match_cnt  <= '0;
                miss_cnt   <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
      // Clear wins over a same-cycle increment; err_pulse is unaffected.
      if (bus.clr) begin
        bus.err_cnt <= '0;
`ifdef PRBS_CHK_BITCNT_EN
        bus.bit_cnt <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_prbs5_checker.sv
// tb_prbs5_checker: directed + randomized bench for prbs5_checker.
// Two checker instances (ERR_W = 16 and ERR_W = 4) see the same stimulus.
// The reference model works on the 31-bit sequence table, a history queue of
// received bits, and a phase index into the table once locked.
module tb_prbs5_checker;

  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_THR = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prbs5_checker_if #(.ERR_W(16)) bus16 ();
  prbs5_checker_if #(.ERR_W(4))  bus4 ();

  prbs5_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_THR(UNLOCK_THR), .ERR_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus16.slave));
  prbs5_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_THR(UNLOCK_THR), .ERR_W(4)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4.slave));

  int checks = 0;
  int errors = 0;

  // Reference sequence and model state
  bit     seq [31];
  bit     hist [$];
  int     src_ph;
  int     nvalid;
  bit     m_locked, m_pulse;
  int     m_match, m_miss, m_ph;
  longint m_err16, m_err4, m_bits16, m_bits4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_locked = 0; m_pulse = 0; m_match = 0; m_miss = 0; m_ph = 0;
    m_err16 = 0; m_err4 = 0; m_bits16 = 0; m_bits4 = 0;
    nvalid = 0;
  endtask

  task automatic model_step(input bit b, input bit v, input bit c);
    bit pred, nz, ok;
    m_pulse = 0;
    if (v) begin
      if (!m_locked) begin
        if (hist.size() >= 5) begin
          pred = hist[hist.size()-5] ^ hist[hist.size()-3];
          nz = 0;
          foreach (hist[i]) if (hist[i]) nz = 1;
          if (b == pred && nz) m_match++;
          else m_match = 0;
        end
        hist.push_back(b);
        while (hist.size() > 5) void'(hist.pop_front());
        if (m_match == LOCK_CNT) begin
          m_locked = 1; m_match = 0; m_miss = 0;
          // Locate the received 5-bit window in the sequence table.
          for (int k = 0; k < 31; k++) begin
            ok = 1;
            for (int i = 0; i < 5; i++)
              if (seq[(k + 27 + i) % 31] != hist[i]) ok = 0;
            if (ok) m_ph = (k + 1) % 31;
          end
        end
      end else begin
        m_bits16 = sat(m_bits16, 24);
        m_bits4  = sat(m_bits4, 12);
        if (b != seq[m_ph]) begin
          m_pulse = 1;
          m_err16 = sat(m_err16, 16);
          m_err4  = sat(m_err4, 4);
          m_miss++;
          if (m_miss == UNLOCK_THR) begin
            m_locked = 0; m_miss = 0; m_match = 0;
            hist.delete();
          end
        end else begin
          m_miss = 0;
        end
        m_ph = (m_ph + 1) % 31;
      end
    end
    if (c) begin
      m_err16 = 0; m_err4 = 0; m_bits16 = 0; m_bits4 = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked16"}, 32'(bus16.locked),    32'(m_locked));
    chk({tag, ".locked4"},  32'(bus4.locked),     32'(m_locked));
    chk({tag, ".pulse16"},  32'(bus16.err_pulse), 32'(m_pulse));
    chk({tag, ".pulse4"},   32'(bus4.err_pulse),  32'(m_pulse));
    chk({tag, ".cnt16"},    32'(bus16.err_cnt),   32'(m_err16));
    chk({tag, ".cnt4"},     32'(bus4.err_cnt),    32'(m_err4));
`ifdef PRBS_CHK_BITCNT_EN
    chk({tag, ".bits16"},   32'(bus16.bit_cnt),   32'(m_bits16));
    chk({tag, ".bits4"},    32'(bus4.bit_cnt),    32'(m_bits4));
`endif
  endtask

  // Called at a negedge: drive one cycle, let it clock, compare at next negedge.
  task automatic step(input string tag, input bit flip, input bit v, input bit c);
    bit b;
    if (v) begin
      b = seq[src_ph] ^ flip;
      src_ph = (src_ph + 1) % 31;
      nvalid++;
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    bus16.din = b; bus16.din_vld = v; bus16.clr = c;
    bus4.din  = b; bus4.din_vld  = v; bus4.clr  = c;
    @(posedge clk);
    model_step(b, v, c);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus16.din = 0; bus16.din_vld = 0; bus16.clr = 0;
    bus4.din  = 0; bus4.din_vld  = 0; bus4.clr  = 0;
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic pulse_reset(input string tag);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk({tag, ".rst_locked"}, 32'(bus16.locked),    32'd0);
    chk({tag, ".rst_pulse"},  32'(bus16.err_pulse), 32'd0);
    chk({tag, ".rst_cnt16"},  32'(bus16.err_cnt),   32'd0);
    chk({tag, ".rst_cnt4"},   32'(bus4.err_cnt),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    src_ph = $urandom_range(0, 30);
  endtask

  initial begin
    seq[0] = 1;
    for (int n = 1; n < 5; n++) seq[n] = 0;
    for (int n = 5; n < 31; n++) seq[n] = seq[n-5] ^ seq[n-3];

    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    src_ph = $urandom_range(0, 30);

    // Clean stream: lock on the 13th bit, then flip bit 40, then bits 50..52.
    for (int i = 1; i <= 200; i++) begin
      step("clean", (i == 40) || (i >= 50 && i <= 52), 1'b1, 1'b0);
      if (i == 12) chk("lock_not_yet", 32'(bus16.locked), 32'd0);
      if (i == 13) chk("lock_at_13", 32'(bus16.locked), 32'd1);
      if (i == 40) chk("single_err_pulse", 32'(bus16.err_pulse), 32'd1);
      if (i == 41) begin
        chk("single_err_pulse_off", 32'(bus16.err_pulse), 32'd0);
        chk("single_err_cnt", 32'(bus16.err_cnt), 32'd1);
        chk("single_err_locked", 32'(bus16.locked), 32'd1);
      end
      if (i == 51) chk("burst_still_locked", 32'(bus16.locked), 32'd1);
      if (i == 52) begin
        chk("burst_unlock", 32'(bus16.locked), 32'd0);
        chk("burst_err_cnt", 32'(bus16.err_cnt), 32'd4);
      end
      if (i == 64) chk("relock_not_yet", 32'(bus16.locked), 32'd0);
      if (i == 65) chk("relock_at_65", 32'(bus16.locked), 32'd1);
    end
    chk("clean_err_total", 32'(bus16.err_cnt), 32'd4);

    // All-zero stream never locks.
    pulse_reset("zero");
    for (int i = 0; i < 100; i++) begin
      bus16.din = 0; bus16.din_vld = 1; bus16.clr = 0;
      bus4.din  = 0; bus4.din_vld  = 1; bus4.clr  = 0;
      @(posedge clk);
      model_step(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check_all("zero");
    end
    chk("zero_never_locked", 32'(bus16.locked), 32'd0);
    chk("zero_err_cnt", 32'(bus16.err_cnt), 32'd0);

    // Alternate errors: ERR_W=4 instance saturates, lock holds, then clr.
    pulse_reset("sat");
    for (int i = 0; i < 20; i++) step("sat_lock", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step("sat_alt", (i % 2) == 0, 1'b1, 1'b0);
    chk("sat_cnt4", 32'(bus4.err_cnt), 32'd15);
    chk("sat_cnt16", 32'(bus16.err_cnt), 32'd20);
    chk("sat_locked", 32'(bus4.locked), 32'd1);
    step("sat_clr", 1'b1, 1'b1, 1'b1);
    chk("clr_wins_cnt", 32'(bus4.err_cnt), 32'd0);
    chk("clr_pulse_kept", 32'(bus4.err_pulse), 32'd1);

    // Five spaced errors, then reset while locked.
    for (int i = 0; i < 20; i++) step("five", (i % 4) == 1, 1'b1, 1'b0);
    chk("five_cnt", 32'(bus16.err_cnt), 32'd5);
    chk("five_locked", 32'(bus16.locked), 32'd1);
    pulse_reset("midrst");

    // Random din_vld on a clean stream: lock after 13 valid bits.
    for (int i = 0; i < 80; i++) begin
      step("vld_rand", 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      chk("vld_rand_lock", 32'(bus16.locked), 32'(nvalid >= 13));
    end

    // Random errors, gaps and clears against the model.
    pulse_reset("rand");
    for (int i = 0; i < 600; i++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      step("rand", ($urandom_range(0, 9) == 0), v, v && ($urandom_range(0, 49) == 0));
    end

    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs5_checker.md
# prbs5_checker

Serial PRBS5 checker, the receive end of the 5-bit pattern generator. It takes one data bit per valid cycle and self-synchronises to the x^5 + x^3 + 1 sequence (period 31). Once locked, it free-runs its own reference, counts bit errors, and reports loss of lock. It sits at the sink of a generator → link → checker test path and supplies pass/fail and BER data to the lab bench.

## Interface
- LOCK_CNT, 8, consecutive predicted-bit matches required to enter LOCKED (≥1)
- UNLOCK_THR, 3, consecutive mismatches in LOCKED that force return to SEARCH (≥1)
- ERR_W, 16, error counter width
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  1  received serial bit
- din_vld  input  1  din is valid this cycle; when low, no state changes
- clr  input  1  synchronous clear of counters; does not affect lock state
- locked  output  1  checker is in LOCKED
- err_pulse  output  1  one-cycle strobe per detected bit error
- err_cnt  output  ERR_W  saturating error count

## Operation
- Shift register r[4:0]; r[0] holds the newest bit. Predicted bit p = r[4] ^ r[2]. Every shift is r <= {r[3:0], x}.
- Fill counter fill (0..5) and match counter match_cnt count toward LOCK_CNT. Miss counter miss_cnt counts toward UNLOCK_THR.
- States (enum): SEARCH, LOCKED.
- SEARCH, per valid bit:
  - fill < 5: shift din, fill++, no compare.
  - fill == 5: compare din with p, then shift din (self-sync; the received bit always enters r).
  - On match with r != 0: match_cnt++.
  - On mismatch, or if r == 0: match_cnt <= 0. An all-zero stream never locks.
  - When match_cnt reaches LOCK_CNT: go to LOCKED; match_cnt <= 0, miss_cnt <= 0.
  - No errors are counted in SEARCH; err_pulse stays 0.
- LOCKED, per valid bit:
  - Shift p, not din (flywheel), so a single flipped bit gives exactly one error.
  - Mismatch: err_pulse, err_cnt++ (saturating at 2^ERR_W−1), miss_cnt++.
  - Match: miss_cnt <= 0.
  - When miss_cnt reaches UNLOCK_THR: go to SEARCH; fill <= 0, match_cnt <= 0. The errors that caused the unlock remain counted.
- clr has priority over an increment in the same cycle: err_cnt <= 0. err_pulse still fires for that cycle's error.
- din_vld low: r, all counters and the state hold; err_pulse <= 0.

## Timing
- Reset values: locked 0, err_pulse 0, err_cnt 0, r 0, fill 0, match_cnt 0, miss_cnt 0, state SEARCH.
- All outputs are registered.
- err_pulse and err_cnt update on the clock edge that samples the offending bit, so they are visible the cycle after din.
- locked rises on the edge sampling the (5 + LOCK_CNT)-th valid bit of a clean stream.
- locked falls on the edge sampling the UNLOCK_THR-th consecutive bad bit.
- Reset mid-operation clears everything asynchronously; the lock sequence restarts from fill = 0.
- Throughput: one bit per clk, with no bubbles required.

## Configuration
- PRBS_CHK_BITCNT_EN:
  - Defined: adds output bit_cnt [ERR_W+8-1:0], a saturating count of valid bits checked while LOCKED. It is cleared by clr and rst, so BER = err_cnt / bit_cnt.
  - Undefined: the port and counter do not exist.

## Structure
- Package prbs5_pkg:
  - state enum {SEARCH, LOCKED}
  - PRBS_LEN = 5
  - tap constants TAP_A = 4, TAP_B = 2
  - function prbs5_next(r) returning the predicted bit
- Sub-module prbs5_lfsr holds r, fill and the shift/predict logic, with a load-select input choosing din or p. The state machine and counters stay in prbs5_checker.

## Test plan
- Clean PRBS5 stream, din_vld high → locked rises after the 13th bit; err_cnt 0 after 200 bits.
- Locked, bit 40 inverted → err_pulse high for exactly 1 cycle, err_cnt = 1, locked stays 1.
- Locked, bits 50–52 inverted → err_cnt = 3, locked falls after the 3rd bad bit, relocks 13 clean bits later.
- All-zero din for 100 cycles → locked never asserts; err_cnt 0.
- ERR_W = 4, locked, every other bit inverted for 40 bits → err_cnt saturates at 15, locked stays 1; clr → 0 next cycle.
- rst pulsed while locked with err_cnt = 5 → locked 0, err_cnt 0 immediately. din_vld toggled randomly on a clean stream → lock is still reached after 13 valid bits.
